// File: rtl/cpu_pkg.sv
// Shared types and constants for the RV32 memory sequencer and its helpers.
package cpu_pkg;

  typedef enum logic [2:0] {
    MS_IDLE   = 3'd0,
    MS_FETCH  = 3'd1,
    MS_EXEC   = 3'd2,
    MS_DATA   = 3'd3,
    MS_COMMIT = 3'd4
  } mseq_state_t;

  localparam logic [1:0]  DW_WORD   = 2'b00;
  localparam logic [1:0]  DW_HALF   = 2'b01;
  localparam logic [1:0]  DW_BYTE   = 2'b10;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Data accesses always go out word-aligned; byte lanes select the bytes.
  function automatic logic [31:0] word_addr(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/mem_sequencer_if.sv
// Single-port memory bus shared by instruction fetch and data access.
interface mem_sequencer_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_sel;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  modport master (
    output bus_req, bus_we, bus_addr, bus_sel, bus_wdata,
    input  bus_rdata, bus_ack
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_sel, bus_wdata,
    output bus_rdata, bus_ack
  );
endinterface

// File: rtl/byte_lane_gen.sv
// Byte-lane enables and alignment check for a load/store of a given width.
module byte_lane_gen
  import cpu_pkg::*;
(
  input  logic [1:0] data_width,
  input  logic [1:0] addr,
  output logic [3:0] sel,
  output logic       misaligned
);

  for (genvar i = 0; i < 4; i++) begin : g_lane
    localparam logic [1:0] LANE = 2'(i);
    always_comb begin
      sel[i] = 1'b1;
      if (data_width == DW_BYTE)      sel[i] = (addr == LANE);
      else if (data_width == DW_HALF) sel[i] = ({addr[1], 1'b0} == (LANE & 2'b10));
    end
  end

  // Width code 11 behaves as a word.
  always_comb begin
    misaligned = (addr != 2'b00);
    if (data_width == DW_HALF)      misaligned = addr[0];
    else if (data_width == DW_BYTE) misaligned = 1'b0;
  end

endmodule

// File: rtl/mem_sequencer.sv
// Multi-cycle fetch / load-store sequencer sharing one memory bus for the RV32 core.
module mem_sequencer
  import cpu_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 nRst,
  input  logic                 halt,
  input  logic [31:0]          pc,
  input  logic [31:0]          data_addr,
  input  logic                 mem_read,
  input  logic                 mem_write,
  input  logic [1:0]           data_width,
  input  logic [31:0]          write_data,
  mem_sequencer_if.master      bus,
  output logic [31:0]          instruction,
  output logic [31:0]          load_data,
  output logic                 pc_enable,
  output logic                 commit,
  output logic                 misaligned,
  output logic                 bus_err
);

  localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT);
  localparam bit               TO_EN  = (TIMEOUT != 0);

  mseq_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      instr_q, instr_d;
  logic [31:0]      load_q, load_d;
  logic             mis_q, mis_d;
  logic             err_q, err_d;
  logic             we_q, we_d;

  logic [3:0]       lane_sel;
  logic             lane_mis;
  logic [CNT_W-1:0] cnt_inc;
  logic             timeout_hit;

  byte_lane_gen u_lanes (
    .data_width (data_width),
    .addr       (data_addr[1:0]),
    .sel        (lane_sel),
    .misaligned (lane_mis)
  );

  assign cnt_inc = cnt_q + CNT_W'(1);
  // Firing on the cycle the count would reach TIMEOUT keeps bus_req high for exactly TIMEOUT cycles.
  assign timeout_hit = TO_EN && (cnt_inc == TO_LIM);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    instr_d = instr_q;
    load_d  = load_q;
    mis_d   = mis_q;
    err_d   = err_q;
    we_d    = we_q;
    case (state_q)
      MS_IDLE: begin
        if (!halt) begin
          state_d = MS_FETCH;
          cnt_d   = '0;
        end
      end
      MS_FETCH: begin
        if (bus.bus_ack) begin
          instr_d = bus.bus_rdata;
          state_d = MS_EXEC;
        end else if (timeout_hit) begin
          instr_d = NOP_INSTR;
          err_d   = 1'b1;
          state_d = MS_COMMIT;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      MS_EXEC: begin
        if (mem_write || mem_read) begin
          we_d = mem_write;
          if (lane_mis) begin
            mis_d   = 1'b1;
            state_d = MS_COMMIT;
          end else begin
            state_d = MS_DATA;
            cnt_d   = '0;
          end
        end else begin
          state_d = MS_COMMIT;
        end
      end
      MS_DATA: begin
        if (bus.bus_ack) begin
          if (!we_q) load_d = bus.bus_rdata;
          state_d = MS_COMMIT;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = MS_COMMIT;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      MS_COMMIT: begin
        if (halt) begin
          state_d = MS_IDLE;
        end else begin
          state_d = MS_FETCH;
          cnt_d   = '0;
        end
      end
      default: state_d = MS_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q <= MS_IDLE;
      cnt_q   <= '0;
      instr_q <= NOP_INSTR;
      load_q  <= '0;
      mis_q   <= 1'b0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      instr_q <= instr_d;
      load_q  <= load_d;
      mis_q   <= mis_d;
      err_q   <= err_d;
      we_q    <= we_d;
    end
  end

  // Strobes depend on state only; address, lanes and data are steered from core inputs.
  assign bus.bus_req = (state_q == MS_FETCH) || (state_q == MS_DATA);
  assign bus.bus_we  = (state_q == MS_DATA) && we_q;

  always_comb begin
    bus.bus_addr  = '0;
    bus.bus_sel   = '0;
    bus.bus_wdata = '0;
    if (state_q == MS_FETCH) begin
      bus.bus_addr = pc;
      bus.bus_sel  = 4'b1111;
    end else if (state_q == MS_DATA) begin
      bus.bus_addr  = word_addr(data_addr);
      bus.bus_sel   = lane_sel;
      bus.bus_wdata = write_data;
    end
  end

  assign pc_enable   = (state_q == MS_COMMIT);
  assign commit      = (state_q == MS_COMMIT);
  assign instruction = instr_q;
  assign load_data   = load_q;
  assign misaligned  = mis_q;
  assign bus_err     = err_q;

endmodule

// File: tb/tb_mem_sequencer.sv
// Directed bench for mem_sequencer: fetch, load, store, misalign, timeout, halt and reset.
module tb_mem_sequencer;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        nRst = 1'b0;
  logic        halt = 1'b1;
  logic [31:0] pc = '0;
  logic [31:0] data_addr = '0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [1:0]  data_width = 2'b00;
  logic [31:0] write_data = '0;
  logic [31:0] instruction, load_data;
  logic        pc_enable, commit, misaligned, bus_err;

  int total = 0;
  int bad = 0;
  int pulses = 0;
  int p0 = 0;

  mem_sequencer_if bif ();

  mem_sequencer #(.TIMEOUT(4), .CNT_W(8)) dut (
    .clk         (clk),
    .nRst        (nRst),
    .halt        (halt),
    .pc          (pc),
    .data_addr   (data_addr),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .data_width  (data_width),
    .write_data  (write_data),
    .bus         (bif.master),
    .instruction (instruction),
    .load_data   (load_data),
    .pc_enable   (pc_enable),
    .commit      (commit),
    .misaligned  (misaligned),
    .bus_err     (bus_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (pc_enable) pulses <= pulses + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  initial begin
    bif.bus_ack   = 1'b0;
    bif.bus_rdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_instr", instruction, NOP_INSTR);
    chk("rst_load", load_data, 32'h0);
    chk("rst_req", {31'b0, bif.bus_req}, 32'd0);
    chk("rst_pcen", {31'b0, pc_enable}, 32'd0);
    chk("rst_mis", {31'b0, misaligned}, 32'd0);
    chk("rst_err", {31'b0, bus_err}, 32'd0);

    // Reset release and zero-wait fetch of an ALU instruction
    nRst = 1'b1; halt = 1'b0; pc = 32'h0;
    @(negedge clk);
    chk("t1_req", {31'b0, bif.bus_req}, 32'd1);
    chk("t1_addr", bif.bus_addr, 32'h0);
    chk("t1_sel", {28'b0, bif.bus_sel}, 32'hF);
    chk("t1_we", {31'b0, bif.bus_we}, 32'd0);
    bif.bus_ack = 1'b1; bif.bus_rdata = 32'h0050_0093; halt = 1'b1;
    @(negedge clk);
    bif.bus_ack = 1'b0;
    chk("t1_exec_req", {31'b0, bif.bus_req}, 32'd0);
    chk("t1_instr", instruction, 32'h0050_0093);
    chk("t1_exec_pcen", {31'b0, pc_enable}, 32'd0);
    @(negedge clk);
    chk("t1_pcen", {31'b0, pc_enable}, 32'd1);
    chk("t1_commit", {31'b0, commit}, 32'd1);
    @(negedge clk);
    chk("t1_idle_pcen", {31'b0, pc_enable}, 32'd0);
    chk("t1_idle_req", {31'b0, bif.bus_req}, 32'd0);
    chk("t1_pulses", 32'(pulses), 32'd1);

    // Load word with two wait states
    pc = 32'h4; mem_read = 1'b1; data_width = DW_WORD; data_addr = 32'h104; halt = 1'b0; p0 = pulses;
    @(negedge clk);
    bif.bus_ack = 1'b1; bif.bus_rdata = 32'h1040_2103; halt = 1'b1;
    @(negedge clk);
    bif.bus_ack = 1'b0;
    chk("t2_exec_req", {31'b0, bif.bus_req}, 32'd0);
    @(negedge clk);
    chk("t2_req", {31'b0, bif.bus_req}, 32'd1);
    chk("t2_addr", bif.bus_addr, 32'h104);
    chk("t2_sel", {28'b0, bif.bus_sel}, 32'hF);
    chk("t2_we", {31'b0, bif.bus_we}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("t2_req_w2", {31'b0, bif.bus_req}, 32'd1);
    bif.bus_ack = 1'b1; bif.bus_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    bif.bus_ack = 1'b0;
    chk("t2_pcen", {31'b0, pc_enable}, 32'd1);
    chk("t2_load", load_data, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("t2_pulses", 32'(pulses - p0), 32'd1);
    mem_read = 1'b0;

    // Store byte to the top lane
    pc = 32'h8; mem_write = 1'b1; data_width = DW_BYTE; data_addr = 32'h203;
    write_data = 32'hAB00_0000; halt = 1'b0;
    @(negedge clk);
    bif.bus_ack = 1'b1; bif.bus_rdata = 32'h20A0_01A3; halt = 1'b1;
    @(negedge clk);
    bif.bus_ack = 1'b0;
    @(negedge clk);
    chk("t3_addr", bif.bus_addr, 32'h200);
    chk("t3_sel", {28'b0, bif.bus_sel}, 32'h8);
    chk("t3_we", {31'b0, bif.bus_we}, 32'd1);
    chk("t3_wdata", bif.bus_wdata, 32'hAB00_0000);
    bif.bus_ack = 1'b1; bif.bus_rdata = 32'h5555_5555;
    @(negedge clk);
    bif.bus_ack = 1'b0;
    chk("t3_pcen", {31'b0, pc_enable}, 32'd1);
    chk("t3_load", load_data, 32'hDEAD_BEEF);
    @(negedge clk);
    mem_write = 1'b0;

    // Misaligned halfword load skips the data access
    pc = 32'hC; mem_read = 1'b1; data_width = DW_HALF; data_addr = 32'h11; halt = 1'b0; p0 = pulses;
    @(negedge clk);
    bif.bus_ack = 1'b1; bif.bus_rdata = 32'h0110_1083; halt = 1'b1;
    @(negedge clk);
    bif.bus_ack = 1'b0;
    chk("t4_exec_req", {31'b0, bif.bus_req}, 32'd0);
    @(negedge clk);
    chk("t4_req", {31'b0, bif.bus_req}, 32'd0);
    chk("t4_pcen", {31'b0, pc_enable}, 32'd1);
    chk("t4_mis", {31'b0, misaligned}, 32'd1);
    chk("t4_load", load_data, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("t4_mis_sticky", {31'b0, misaligned}, 32'd1);
    chk("t4_pulses", 32'(pulses - p0), 32'd1);
    mem_read = 1'b0;

    // Fetch timeout after four unacknowledged request cycles
    pc = 32'h10; halt = 1'b0; p0 = pulses;
    @(negedge clk);
    chk("t5_req1", {31'b0, bif.bus_req}, 32'd1);
    halt = 1'b1;
    repeat (3) @(negedge clk);
    chk("t5_req4", {31'b0, bif.bus_req}, 32'd1);
    chk("t5_err_pre", {31'b0, bus_err}, 32'd0);
    @(negedge clk);
    chk("t5_req_drop", {31'b0, bif.bus_req}, 32'd0);
    chk("t5_pcen", {31'b0, pc_enable}, 32'd1);
    chk("t5_err", {31'b0, bus_err}, 32'd1);
    chk("t5_instr", instruction, NOP_INSTR);
    @(negedge clk);
    chk("t5_err_sticky", {31'b0, bus_err}, 32'd1);
    chk("t5_pulses", 32'(pulses - p0), 32'd1);

    // Halt raised during DATA lets the access finish
    pc = 32'h14; mem_read = 1'b1; data_width = DW_WORD; data_addr = 32'h108; halt = 1'b0; p0 = pulses;
    @(negedge clk);
    bif.bus_ack = 1'b1; bif.bus_rdata = 32'h1080_2283;
    @(negedge clk);
    bif.bus_ack = 1'b0;
    @(negedge clk);
    halt = 1'b1;
    @(negedge clk);
    chk("t6_req_held", {31'b0, bif.bus_req}, 32'd1);
    bif.bus_ack = 1'b1; bif.bus_rdata = 32'h1234_5678;
    @(negedge clk);
    bif.bus_ack = 1'b0;
    chk("t6_pcen", {31'b0, pc_enable}, 32'd1);
    chk("t6_load", load_data, 32'h1234_5678);
    @(negedge clk);
    chk("t6_idle_req", {31'b0, bif.bus_req}, 32'd0);
    chk("t6_idle_pcen", {31'b0, pc_enable}, 32'd0);
    chk("t6_pulses", 32'(pulses - p0), 32'd1);
    mem_read = 1'b0;

    // Reset in the middle of a fetch
    pc = 32'h18; halt = 1'b0; p0 = pulses;
    @(negedge clk);
    chk("t7_req", {31'b0, bif.bus_req}, 32'd1);
    chk("t7_addr", bif.bus_addr, 32'h18);
    #2 nRst = 1'b0;
    #1;
    chk("t7_rst_req", {31'b0, bif.bus_req}, 32'd0);
    chk("t7_rst_pcen", {31'b0, pc_enable}, 32'd0);
    chk("t7_rst_mis", {31'b0, misaligned}, 32'd0);
    chk("t7_rst_err", {31'b0, bus_err}, 32'd0);
    @(negedge clk);
    nRst = 1'b1;
    @(negedge clk);
    chk("t7_refetch_req", {31'b0, bif.bus_req}, 32'd1);
    chk("t7_refetch_addr", bif.bus_addr, 32'h18);
    bif.bus_ack = 1'b1; bif.bus_rdata = 32'h0010_0113; halt = 1'b1;
    @(negedge clk);
    bif.bus_ack = 1'b0;
    @(negedge clk);
    chk("t7_pcen", {31'b0, pc_enable}, 32'd1);
    chk("t7_instr", instruction, 32'h0010_0113);
    @(negedge clk);
    chk("t7_pulses", 32'(pulses - p0), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
